// File: rtl/toggle_hs_pkg.sv
// Shared types and constants for the toggle-signalling handshake blocks.
package toggle_hs_pkg;

  typedef enum logic [1:0] {ARM, IDLE, HOLD} state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic int unsigned arm_cnt_w();
    return $clog2(SYNC_STAGES_MAX + 2);
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop level synchroniser for an asynchronous toggle; reused on the tx ack path.
module toggle_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[STAGES-2:0], d};
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Toggle-handshake receiver: syncs req toggle, captures bundled data, valid/ready out, ack toggle back.
// Optional parity check on the bundled word when TOGGLE_RX_PARITY_EN is defined.
module toggle_handshake_rx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              input_clock_c,
  input  logic              input_reset_r,
  input  logic              req_tgl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  input  logic              ovr_clr_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_tgl_o,
  output logic              overrun_o,
  output logic [CNT_W-1:0]  count_o
`ifdef TOGGLE_RX_PARITY_EN
  ,
  input  logic              par_i,
  output logic              par_err_o
`endif
);

  localparam int unsigned ARM_W = arm_cnt_w();

  state_t           state, state_nxt;
  logic [ARM_W-1:0] arm_cnt;
  logic             s, prev_req, tgl, arm_done;
  logic             track_req, capture, handshake, ovr_set;

  toggle_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (input_clock_c),
    .rst (input_reset_r),
    .d   (req_tgl_i),
    .q   (s)
  );

  assign tgl      = s ^ prev_req;
  assign arm_done = (arm_cnt == ARM_W'(SYNC_STAGES));

  always_ff @(posedge input_clock_c or posedge input_reset_r) begin
    if (input_reset_r) state <= ARM;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARM:     if (arm_done) state_nxt = IDLE;
      IDLE:    if (tgl) state_nxt = HOLD;
      HOLD:    if (valid_o && ready_i) state_nxt = IDLE;
      default: state_nxt = ARM;
    endcase
  end

  always_comb begin
    track_req = (state == ARM);
    capture   = (state == IDLE) && tgl;
    handshake = (state == HOLD) && valid_o && ready_i;
    ovr_set   = (state == HOLD) && tgl;
  end

  // prev_req is frozen in HOLD so a toggle arriving there stays pending until IDLE.
  always_ff @(posedge input_clock_c or posedge input_reset_r) begin
    if (input_reset_r) begin
      arm_cnt   <= '0;
      prev_req  <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      ack_tgl_o <= 1'b0;
      overrun_o <= 1'b0;
      count_o   <= '0;
    end else begin
      if (track_req && !arm_done) arm_cnt <= arm_cnt + ARM_W'(1);
      if (track_req || capture)   prev_req <= s;
      if (capture) begin
        data_o  <= data_i;
        valid_o <= 1'b1;
      end
      if (handshake) begin
        valid_o   <= 1'b0;
        ack_tgl_o <= ~ack_tgl_o;
        count_o   <= count_o + CNT_W'(1);
      end
      if (ovr_set)        overrun_o <= 1'b1;
      else if (ovr_clr_i) overrun_o <= 1'b0;
    end
  end

`ifdef TOGGLE_RX_PARITY_EN
  always_ff @(posedge input_clock_c or posedge input_reset_r) begin
    if (input_reset_r)  par_err_o <= 1'b0;
    else if (capture)   par_err_o <= ^{data_i, par_i};
    else if (handshake) par_err_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx: vector table plus directed multi-cycle sequences.
module tb_toggle_handshake_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic       valid_o, ack_tgl_o, overrun_o;
  logic [7:0] data_o, count_o;
`ifdef TOGGLE_RX_PARITY_EN
  logic       par = 1'b0;
  logic       par_err_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .input_clock_c (clk),
    .input_reset_r (rst),
    .req_tgl_i     (req),
    .data_i        (data),
    .ready_i       (ready),
    .ovr_clr_i     (clr),
    .valid_o       (valid_o),
    .data_o        (data_o),
    .ack_tgl_o     (ack_tgl_o),
    .overrun_o     (overrun_o),
    .count_o       (count_o)
`ifdef TOGGLE_RX_PARITY_EN
    ,
    .par_i         (par),
    .par_err_o     (par_err_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ack;
    logic       exp_ovr;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic rd, input logic c,
                              input logic ev, input logic [7:0] ed, input logic ea,
                              input logic eo, input logic [7:0] ec);
    vec_t v;
    v.req = r; v.data = d; v.ready = rd; v.clr = c;
    v.exp_valid = ev; v.exp_data = ed; v.exp_ack = ea; v.exp_ovr = eo; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_o === 1'b1) break;
    end
    chk(nm, 32'(valid_o), 32'd1);
  endtask

  initial begin
    // Reset with request already high: level must be absorbed
    rst = 1'b1; req = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data",  32'(data_o), 32'd0);
    chk("rst_ack",   32'(ack_tgl_o), 32'd0);
    chk("rst_ovr",   32'(overrun_o), 32'd0);
    chk("rst_cnt",   32'(count_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("absorb_valid", 32'(valid_o), 32'd0);
    end
    chk("absorb_cnt", 32'(count_o), 32'd0);
    chk("absorb_ack", 32'(ack_tgl_o), 32'd0);

    rst = 1'b1; req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();

    // Basic transfer, then a stalled consumer with data_i changing during HOLD
    tbl[0]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0);
    tbl[1]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0);
    tbl[2]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd0);
    tbl[3]  = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1);
    tbl[4]  = mk(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1);
    tbl[5]  = mk(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'd1);
    tbl[6]  = mk(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd1);
    tbl[7]  = mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd1);
    tbl[8]  = mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd1);
    tbl[9]  = mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd1);
    tbl[10] = mk(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd1);
    tbl[11] = mk(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'd2);
    tbl[12] = mk(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req; data = tbl[i].data; ready = tbl[i].ready; clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(valid_o),   32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_data", i),  32'(data_o),    32'(tbl[i].exp_data));
      chk($sformatf("vec%0d_ack", i),   32'(ack_tgl_o), 32'(tbl[i].exp_ack));
      chk($sformatf("vec%0d_ovr", i),   32'(overrun_o), 32'(tbl[i].exp_ovr));
      chk($sformatf("vec%0d_cnt", i),   32'(count_o),   32'(tbl[i].exp_cnt));
    end

    // Overrun: second toggle during HOLD, clear held high so set must win
    req = 1'b1; data = 8'h11; ready = 1'b0;
    repeat (3) tick();
    chk("ovr_cap_valid", 32'(valid_o), 32'd1);
    chk("ovr_cap_data",  32'(data_o), 32'h11);
    req = 1'b0; data = 8'h22; clr = 1'b1;
    repeat (3) tick();
    chk("ovr_set_wins", 32'(overrun_o), 32'd1);
    chk("ovr_hold_data", 32'(data_o), 32'h11);
    clr = 1'b0; ready = 1'b1;
    tick();
    chk("ovr_hs_valid", 32'(valid_o), 32'd0);
    chk("ovr_hs_cnt",   32'(count_o), 32'd3);
    chk("ovr_hs_ack",   32'(ack_tgl_o), 32'd1);
    tick();
    chk("ovr_recap_valid", 32'(valid_o), 32'd1);
    chk("ovr_recap_data",  32'(data_o), 32'h22);
    tick();
    chk("ovr_hs2_cnt", 32'(count_o), 32'd4);
    chk("ovr_hs2_ack", 32'(ack_tgl_o), 32'd0);
    chk("ovr_sticky",  32'(overrun_o), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clear", 32'(overrun_o), 32'd0);

    // Reset mid-transfer must drop valid without a clock edge
    req = 1'b1; data = 8'h5A; ready = 1'b0;
    repeat (3) tick();
    chk("mid_valid", 32'(valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_async_valid", 32'(valid_o), 32'd0);
    chk("mid_async_cnt",   32'(count_o), 32'd0);
    req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("mid_after_valid", 32'(valid_o), 32'd0);

    // 256 back-to-back transfers: counter wraps, ack parity matches req
    ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      req = ~req; data = 8'(i);
      wait_valid("wrap_valid");
      chk("wrap_data", 32'(data_o), 32'(i[7:0]));
      tick();
    end
    chk("wrap_cnt",   32'(count_o), 32'd0);
    chk("wrap_ack",   32'(ack_tgl_o), 32'(req));
    chk("wrap_valid_low", 32'(valid_o), 32'd0);

`ifdef TOGGLE_RX_PARITY_EN
    ready = 1'b0; req = ~req; data = 8'h03; par = 1'b1;
    wait_valid("par_valid1");
    chk("par_err_set", 32'(par_err_o), 32'd1);
    ready = 1'b1;
    tick();
    chk("par_err_clr", 32'(par_err_o), 32'd0);
    ready = 1'b0; req = ~req; par = 1'b0;
    wait_valid("par_valid2");
    chk("par_ok", 32'(par_err_o), 32'd0);
    ready = 1'b1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
